// File: rtl/data_mem_sized.sv
// Word-organised RV32I data memory with sub-word access, valid/ready request channel,
// configurable wait states and misalignment detection. Optional: DATA_MEM_ERR_STICKY_EN.
module data_mem_sized #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        wr_sel,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic        rsp_valid,
  output logic [31:0] rd_data,
  output logic        misaligned
`ifdef DATA_MEM_ERR_STICKY_EN
  ,
  input  logic        err_clr,
  output logic        err_sticky
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic        wr_sel_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic        cur_wr;
  logic [1:0]  cur_size;
  logic        cur_uns;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_mis;
  logic [AW-1:0] cur_idx;
  logic [3:0]  cur_be;
  logic [31:0] cur_wlanes;
  logic [31:0] rword;
  logic [31:0] resp_data;
  logic        commit;
  logic        unused_addr;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] a, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {a, 3'b000};
    b  = signed'(sh[7:0]);
    h  = signed'(sh[15:0]);
    case (sz)
      2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // In IDLE the request is taken straight from the ports so a zero-wait access commits
  // on its acceptance edge; later states use the latched copy.
  always_comb begin
    cur_wr    = wr_sel_p0;
    cur_size  = size_p0;
    cur_uns   = uns_p0;
    cur_addr  = addr_p0;
    cur_wdata = wdata_p0;
    if (state == S_IDLE) begin
      cur_wr    = wr_sel;
      cur_size  = size;
      cur_uns   = unsigned_ld;
      cur_addr  = addr;
      cur_wdata = wr_data;
    end
  end

  assign cur_mis     = is_misaligned(cur_size, cur_addr[1:0]);
  assign cur_idx     = cur_addr[AW+1:2];
  assign cur_be      = lane_mask(cur_size, cur_addr[1:0]);
  assign cur_wlanes  = lane_data(cur_size, cur_wdata);
  assign rword       = mem[cur_idx];
  assign resp_data   = (cur_wr || cur_mis) ? 32'd0
                     : load_extract(rword, cur_size, cur_addr[1:0], cur_uns);
  assign unused_addr = ^cur_addr[31:AW+2];

  // Edge that enters RESP; gated by rst_n so an aborting reset never writes.
  assign commit = rst_n && (((state == S_IDLE) && req_valid && NO_WAIT) ||
                            ((state == S_WAIT) && (cnt == 4'd0)));

  // p0: request capture
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      wr_sel_p0 <= wr_sel;
      size_p0   <= size;
      uns_p0    <= unsigned_ld;
      addr_p0   <= addr;
      wdata_p0  <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && cur_wr && !cur_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rd_data    <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (NO_WAIT) begin
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rd_data    <= resp_data;
              misaligned <= cur_mis;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rd_data    <= resp_data;
            misaligned <= cur_mis;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef DATA_MEM_ERR_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_sticky <= 1'b0;
    else if (commit && cur_mis)  err_sticky <= 1'b1;
    else if (err_clr)            err_sticky <= 1'b0;
  end
`endif

endmodule
